// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready data-memory target with programmable wait states.
// One request in flight; access happens on the handshake edge (LATENCY=0) or when the wait counter hits 1.
module dmem_responder #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic        CLK,
   input  logic        resetl,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_rdata,
   output logic        resp_err
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        wr_q, wr_d, err_q, err_d;
   logic [63:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
   logic [63:0] mem [DEPTH];

   logic          in_idle, access, acc_wr, bad;
   logic [63:0]   acc_addr, acc_wdata;
   logic [AW-1:0] acc_idx;

   // With zero latency the access uses the live request; otherwise the latched copy.
   assign in_idle   = state_q == IDLE;
   assign access    = (in_idle && req_valid && LATENCY == 0) || (state_q == WAIT && cnt_q == 4'd1);
   assign acc_wr    = in_idle ? req_write : wr_q;
   assign acc_addr  = in_idle ? req_addr  : addr_q;
   assign acc_wdata = in_idle ? req_wdata : wdata_q;
   assign acc_idx   = acc_addr[3 +: AW];
   assign bad       = (acc_addr[2:0] != 3'd0) || ((acc_addr[63:3] >> AW) != 61'd0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: if (req_valid) begin
            wr_d    = req_write;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            cnt_d   = 4'(LATENCY);
            state_d = (LATENCY == 0) ? RESP : WAIT;
         end
         WAIT: begin
            cnt_d   = cnt_q - 4'd1;
            state_d = (cnt_q == 4'd1) ? RESP : WAIT;
         end
         RESP: if (resp_ready) begin
            state_d = IDLE;
            rdata_d = 64'd0;
            err_d   = 1'b0;
         end
         default: state_d = IDLE;
      endcase
      if (access) begin
         err_d   = bad;
         rdata_d = (bad || acc_wr) ? 64'd0 : mem[acc_idx];
      end
   end

   always_ff @(posedge CLK or negedge resetl) begin
      if (!resetl) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         wr_q    <= 1'b0;
         addr_q  <= 64'd0;
         wdata_q <= 64'd0;
         rdata_q <= 64'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Storage is not reset; writes are blocked while reset is held.
   always_ff @(posedge CLK) begin
      if (resetl && access && acc_wr && !bad) mem[acc_idx] <= acc_wdata;
   end

   assign req_ready  = in_idle;
   assign resp_valid = state_q == RESP;
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: three responders (LATENCY 2, 0, 3) driven by directed and random
// transactions, checked every cycle against a word-array model of the memory.
module tb_dmem_responder;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0, n_fail = 0;

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction

   for (genvar g = 0; g < 3; g++) begin : gi
      localparam int L = (g == 0) ? 2 : ((g == 1) ? 0 : 3);
      localparam int D = 256;
      logic        resetl = 1'b0, req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
      logic        req_ready, resp_valid, resp_err;
      logic [63:0] req_addr = 64'd0, req_wdata = 64'd0, resp_rdata;
      logic [63:0] mem [D];
      logic        known [D];
      logic        done = 1'b0;

      dmem_responder #(.DEPTH(D), .LATENCY(L)) u_dut (
         .CLK(clk), .resetl(resetl), .req_valid(req_valid), .req_ready(req_ready),
         .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
         .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
         .resp_err(resp_err)
      );

      function automatic string nm(string s);
         return $sformatf("L%0d %s", L, s);
      endfunction

      task automatic idle_chk(string s);
         chk(nm({s, " req_ready"}), 64'(req_ready), 64'd1);
         chk(nm({s, " resp_valid"}), 64'(resp_valid), 64'd0);
         chk(nm({s, " resp_rdata"}), resp_rdata, 64'd0);
         chk(nm({s, " resp_err"}), 64'(resp_err), 64'd0);
      endtask

      // Called just after a negedge with the DUT idle; returns just after a negedge.
      task automatic do_req(input logic w, input logic [63:0] a, input logic [63:0] d,
                            input int bp, output logic [63:0] rd, output logic e, output int hs);
         logic bad;
         int idx;
         logic [63:0] exp;
         bad = (a[2:0] != 3'd0) || (a[63:3] >= 61'(D));
         idx = int'(a[10:3]);
         exp = (bad || w) ? 64'd0 : mem[idx];
         rd = 64'd0;
         e = 1'b0;
         chk(nm("req_ready before"), 64'(req_ready), 64'd1);
         req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; resp_ready = 1'b0;
         @(posedge clk);
         #1 hs = cyc;
         // Competing, changing request: must be ignored until the next IDLE.
         req_write = 1'($urandom);
         for (int k = 0; k <= L + bp; k++) begin
            req_addr  = {53'd0, 8'($urandom), 3'd0};
            req_wdata = {$urandom, $urandom};
            @(negedge clk);
            chk(nm("req_ready busy"), 64'(req_ready), 64'd0);
            chk(nm("resp_valid timing"), 64'(resp_valid), 64'(k >= L));
            if (k >= L) begin
               chk(nm("resp_err"), 64'(resp_err), 64'(bad));
               if (bad || w || known[idx]) chk(nm("resp_rdata"), resp_rdata, exp);
               rd = resp_rdata;
               e = resp_err;
            end
            if (k == L + bp) resp_ready = 1'b1;
         end
         @(posedge clk);
         #1 req_valid = 1'b0; resp_ready = 1'b0;
         if (!bad && w) begin
            mem[idx] = d;
            known[idx] = 1'b1;
         end
         @(negedge clk);
         idle_chk("after resp");
      endtask

      initial begin
         logic [63:0] rd, a;
         logic e;
         int h1, h2, sel, idx;
         for (int i = 0; i < D; i++) known[i] = 1'b0;
         repeat (3) @(negedge clk);
         idle_chk("in reset");
         resetl = 1'b1;
         @(negedge clk);
         idle_chk("post reset");

         do_req(1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, 0, rd, e, h1);
         chk(nm("store rdata"), rd, 64'd0);
         chk(nm("store err"), 64'(e), 64'd0);
         do_req(1'b0, 64'h10, 64'd0, 5, rd, e, h1);
         chk(nm("load after store"), rd, 64'hDEADBEEF_CAFEF00D);
         do_req(1'b1, 64'h13, 64'h5555, 1, rd, e, h1);
         chk(nm("misaligned err"), 64'(e), 64'd1);
         chk(nm("misaligned rdata"), rd, 64'd0);
         do_req(1'b0, 64'h10, 64'd0, 0, rd, e, h1);
         chk(nm("load after bad store"), rd, 64'hDEADBEEF_CAFEF00D);
         do_req(1'b0, 64'h800, 64'd0, 2, rd, e, h1);
         chk(nm("range err"), 64'(e), 64'd1);
         chk(nm("range rdata"), rd, 64'd0);
         do_req(1'b0, 64'h8000_0000_0000_0010, 64'd0, 0, rd, e, h1);
         chk(nm("high addr err"), 64'(e), 64'd1);

         do_req(1'b1, 64'h0, 64'h0123_4567_89AB_CDEF, 0, rd, e, h1);
         do_req(1'b1, 64'h8, 64'hFEDC_BA98_7654_3210, 0, rd, e, h2);
         chk(nm("throughput"), 64'(h2 - h1), 64'(L + 2));
         do_req(1'b0, 64'h0, 64'd0, 0, rd, e, h1);
         chk(nm("b2b load 0"), rd, 64'h0123_4567_89AB_CDEF);
         do_req(1'b0, 64'h8, 64'd0, 0, rd, e, h2);
         chk(nm("b2b load 8"), rd, 64'hFEDC_BA98_7654_3210);
         chk(nm("load throughput"), 64'(h2 - h1), 64'(L + 2));

         do_req(1'b1, 64'h20, 64'h2222, 0, rd, e, h1);
         req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h20; req_wdata = 64'h1111;
         @(posedge clk);
         @(negedge clk);
         resetl = 1'b0;
         #1 idle_chk("async reset");
         req_valid = 1'b0;
         // With no wait states the store commits on the handshake edge itself.
         if (L == 0) mem[4] = 64'h1111;
         @(negedge clk);
         resetl = 1'b1;
         @(negedge clk);
         idle_chk("after mid reset");
         do_req(1'b0, 64'h20, 64'd0, 0, rd, e, h1);
         chk(nm("mid reset store"), rd, (L == 0) ? 64'h1111 : 64'h2222);

         for (int i = 0; i < 16; i++) do_req(1'b1, 64'(i * 8), {$urandom, $urandom}, 0, rd, e, h1);
         repeat (80) begin
            sel = int'($urandom_range(0, 7));
            idx = int'($urandom_range(0, 15));
            a = (sel == 0) ? 64'(idx * 8 + int'($urandom_range(1, 7))) :
                (sel == 1) ? 64'((D + int'($urandom_range(0, 15))) * 8) :
                (sel == 2) ? {1'b1, 63'($urandom)} : 64'(idx * 8);
            do_req(1'($urandom), a, {$urandom, $urandom}, int'($urandom_range(0, 3)), rd, e, h1);
         end
         done = 1'b1;
      end
   end

   initial begin
      for (int t = 0; t < 30000 && !(gi[0].done && gi[1].done && gi[2].done); t++) @(posedge clk);
      n_chk++;
      if (!(gi[0].done && gi[1].done && gi[2].done)) begin
         n_fail++;
         $display("FAIL timeout: got not done expected all done");
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
